// File: rtl/video_timing_pkg.sv
// Mode constant sets, sync polarity levels and the bundle of per-pixel timing flags
// shared by the raster timing generator and its users.
package video_timing_pkg;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        h_pol;
        logic        v_pol;
    } mode_t;

    localparam mode_t VGA_640x480 = '{
        h_active: 32'd640,  h_fp: 32'd16,  h_sync: 32'd96, h_bp: 32'd48,
        v_active: 32'd480,  v_fp: 32'd10,  v_sync: 32'd2,  v_bp: 32'd33,
        h_pol: SYNC_ACTIVE_LOW, v_pol: SYNC_ACTIVE_LOW
    };

    localparam mode_t HD_1280x720 = '{
        h_active: 32'd1280, h_fp: 32'd110, h_sync: 32'd40, h_bp: 32'd220,
        v_active: 32'd720,  v_fp: 32'd5,   v_sync: 32'd5,  v_bp: 32'd20,
        h_pol: SYNC_ACTIVE_HIGH, v_pol: SYNC_ACTIVE_HIGH
    };

    // Sync levels here are already at output polarity, not "asserted" flags.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } sync_bus_t;

    localparam int unsigned SYNC_BUS_W = $bits(sync_bus_t);

    function automatic sync_bus_t sync_idle(input logic h_pol, input logic v_pol);
        sync_bus_t b;
        b.de = 1'b0;
        b.hs = ~h_pol;
        b.vs = ~v_pol;
        b.ls = 1'b0;
        b.fs = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Clock-enabled shift register of DEPTH stages with a reset value per stage;
// DEPTH=0 degenerates to a wire.
module pipe_delay #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl_s;
        assign unused_ctrl_s = clk ^ rst ^ en;
        assign q = d;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_r [DEPTH];

        // Shift chain; every stage holds while en is low
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_r[i] <= RESET_VAL;
                end
            end else if (en) begin
                stage_r[0] <= d;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_r[i] <= stage_r[i-1];
                end
            end
        end

        assign q = stage_r[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: x/y counters, registered decode of
// DE/sync/strobes, and a delay line to match the downstream pixel pipeline.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640x480.h_active,
    parameter int unsigned H_FP     = VGA_640x480.h_fp,
    parameter int unsigned H_SYNC   = VGA_640x480.h_sync,
    parameter int unsigned H_BP     = VGA_640x480.h_bp,
    parameter int unsigned V_ACTIVE = VGA_640x480.v_active,
    parameter int unsigned V_FP     = VGA_640x480.v_fp,
    parameter int unsigned V_SYNC   = VGA_640x480.v_sync,
    parameter int unsigned V_BP     = VGA_640x480.v_bp,
    parameter logic        H_POL    = VGA_640x480.h_pol,
    parameter logic        V_POL    = VGA_640x480.v_pol,
    parameter int unsigned DELAY    = 0,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    if ((H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0) ||
        (DELAY > 15)) begin : g_param_err
        $error("video_timing_gen: zero porch/sync/active parameter or DELAY > 15");
    end

    localparam sync_bus_t IDLE = sync_idle(H_POL, V_POL);

    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic          x_wrap_s;
    logic          y_wrap_s;
    sync_bus_t     raw_s;
    sync_bus_t     raw_r;
    sync_bus_t     out_s;

    assign x_wrap_s = (x_r == XW'(H_TOTAL - 1));
    assign y_wrap_s = (y_r == YW'(V_TOTAL - 1));

    // Raster counters: y advances only when x wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r <= '0;
            y_r <= '0;
        end else if (en) begin
            if (x_wrap_s) begin
                x_r <= '0;
                y_r <= y_wrap_s ? '0 : (y_r + YW'(1));
            end else begin
                x_r <= x_r + XW'(1);
            end
        end
    end

    // Decode of the current coordinate; vsync depends on y only, so it moves at line start
    always_comb begin
        raw_s    = IDLE;
        raw_s.de = (x_r < XW'(H_ACTIVE)) && (y_r < YW'(V_ACTIVE));
        raw_s.hs = ((x_r >= XW'(H_ACTIVE + H_FP)) && (x_r < XW'(H_ACTIVE + H_FP + H_SYNC)))
                   ? H_POL : ~H_POL;
        raw_s.vs = ((y_r >= YW'(V_ACTIVE + V_FP)) && (y_r < YW'(V_ACTIVE + V_FP + V_SYNC)))
                   ? V_POL : ~V_POL;
        raw_s.ls = (x_r == '0);
        raw_s.fs = (x_r == '0) && (y_r == '0);
    end

    // Raw decode stage, one enabled cycle behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_r <= IDLE;
        end else if (en) begin
            raw_r <= raw_s;
        end
    end

    pipe_delay #(
        .WIDTH     (SYNC_BUS_W),
        .DEPTH     (DELAY),
        .RESET_VAL (IDLE)
    ) u_pipe_delay (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (raw_r),
        .q   (out_s)
    );

    assign x           = x_r;
    assign y           = y_r;
    assign de          = out_s.de;
    assign hsync       = out_s.hs;
    assign vsync       = out_s.vs;
    assign line_start  = out_s.ls;
    assign frame_start = out_s.fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: two small-raster instances (DELAY=0 active-low, DELAY=3 active-high)
// checked each cycle against an arithmetic model driven by random en/rst.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int HA = 10, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          de;
        logic          hs;
        logic          vs;
        logic          ls;
        logic          fs;
    } obs_t;

    typedef struct packed {
        int   n;
        obs_t e0;
        obs_t e3;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [XW-1:0] x0, x3;
    logic [YW-1:0] y0, y3;
    logic de0, hs0, vs0, ls0, fs0;
    logic de3, hs3, vs3, ls3, fs3;

    exp_t q[$];
    int   n = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .DELAY(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .x(x0), .y(y0), .de(de0), .hsync(hs0),
        .vsync(vs0), .line_start(ls0), .frame_start(fs0)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1), .DELAY(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .x(x3), .y(y3), .de(de3), .hsync(hs3),
        .vsync(vs3), .line_start(ls3), .frame_start(fs3)
    );

    // n = enabled edges since reset; flags describe the coordinate reached 1+d edges earlier
    function automatic obs_t model(input int cnt, input int d, input logic hpol, input logic vpol);
        obs_t o;
        int   m, mx, my;
        o.x = XW'(cnt % HT);
        o.y = YW'((cnt / HT) % VT);
        if (cnt < 1 + d) begin
            o.de = 1'b0;
            o.hs = ~hpol;
            o.vs = ~vpol;
            o.ls = 1'b0;
            o.fs = 1'b0;
        end else begin
            m    = cnt - 1 - d;
            mx   = m % HT;
            my   = (m / HT) % VT;
            o.de = (mx < HA) && (my < VA);
            o.hs = ((mx >= HA + HF) && (mx < HA + HF + HS)) ? hpol : ~hpol;
            o.vs = ((my >= VA + VF) && (my < VA + VF + VS)) ? vpol : ~vpol;
            o.ls = (mx == 0);
            o.fs = (mx == 0) && (my == 0);
        end
        return o;
    endfunction

    task automatic step(input logic r, input logic e);
        exp_t item;
        @(negedge clk);
        rst = r;
        en  = e;
        if (r) n = 0;
        else if (e) n = n + 1;
        item.n  = n;
        item.e0 = model(n, 0, 1'b0, 1'b0);
        item.e3 = model(n, 3, 1'b1, 1'b1);
        q.push_back(item);
    endtask

    function automatic void check(input string name, input int cnt, input obs_t got, input obs_t exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s n=%0d got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                     name, cnt, got.x, got.y, got.de, got.hs, got.vs, got.ls, got.fs,
                     exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.ls, exp.fs);
        end
    endfunction

    // Monitor: after every edge, pop the expectation issued for that edge and compare
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("dly0", e.n, {x0, y0, de0, hs0, vs0, ls0, fs0}, e.e0);
            check("dly3", e.n, {x3, y3, de3, hs3, vs3, ls3, fs3}, e.e3);
        end
    end

    initial begin
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        // Three full frames free-running, including the (HT-1,VT-1) wrap
        repeat (3 * HT * VT + 20) step(1'b0, 1'b1);
        // 50% random enable
        repeat (900) step(1'b0, 1'($urandom_range(0, 1)));
        // Mid-frame resets, some coinciding with en=0
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(20, 250)) step(1'b0, 1'($urandom_range(0, 1)));
            step(1'b1, 1'($urandom_range(0, 1)));
        end
        repeat (HT * VT + 30) step(1'b0, 1'b1);

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
